// File: rtl/raster_pkg.sv
// raster_pkg: FSM state encoding and centre-origin to screen coordinate helper for line_raster_stream
package raster_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, WALK, DONE} state_t;
  function automatic int centre_to_screen(input int c, input int half, input bit flip);
    return flip ? half - c : half + c;
  endfunction
endpackage

// File: rtl/bresenham_step.sv
// bresenham_step: combinational Bresenham advance; in: cur_x/cur_y, end_x/end_y, dx, dy, step_x/step_y, err; out: next_x/next_y, next_err, at_end
module bresenham_step #(
  parameter int CW = 15
) (
  input  logic signed [CW-1:0] cur_x,
  input  logic signed [CW-1:0] cur_y,
  input  logic signed [CW-1:0] end_x,
  input  logic signed [CW-1:0] end_y,
  input  logic signed [CW-1:0] dx,
  input  logic signed [CW-1:0] dy,
  input  logic signed [CW-1:0] step_x,
  input  logic signed [CW-1:0] step_y,
  input  logic signed [CW:0]   err,
  output logic signed [CW-1:0] next_x,
  output logic signed [CW-1:0] next_y,
  output logic signed [CW:0]   next_err,
  output logic                 at_end
);
  logic signed [CW+1:0] e2, err_e, dx_e, dy_e;
  logic mx, my;
  always_comb begin
    err_e = (CW+2)'(err);
    dx_e = (CW+2)'(dx);
    dy_e = (CW+2)'(dy);
    e2 = err_e <<< 1;
    mx = e2 > -dy_e;
    my = e2 < dx_e;
    next_x = mx ? cur_x + step_x : cur_x;
    next_y = my ? cur_y + step_y : cur_y;
    next_err = (CW+1)'(err_e - (mx ? dy_e : '0) + (my ? dx_e : '0));
    at_end = cur_x == end_x && cur_y == end_y;
  end
endmodule

// File: rtl/line_raster_stream.sv
// line_raster_stream: Bresenham line walker emitting clipped on-screen pixels as a valid/ready stream
//   in : clk, rst, line_valid, start_x/start_y/end_x/end_y (signed, centre origin, +y up), line_color, pix_ready
//   out: line_ready, pix_valid, pix_x, pix_y, pix_color, pix_addr, done (end-of-segment pulse), busy
import raster_pkg::*;
module line_raster_stream #(
  parameter int COORD_W  = 13,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COLOR_W  = 4,
  parameter int X_W      = $clog2(SCREEN_W),
  parameter int Y_W      = $clog2(SCREEN_H),
  parameter int ADDR_W   = $clog2(SCREEN_W*SCREEN_H)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_valid,
  output logic                      line_ready,
  input  logic signed [COORD_W-1:0] start_x,
  input  logic signed [COORD_W-1:0] start_y,
  input  logic signed [COORD_W-1:0] end_x,
  input  logic signed [COORD_W-1:0] end_y,
  input  logic [COLOR_W-1:0]        line_color,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [X_W-1:0]            pix_x,
  output logic [Y_W-1:0]            pix_y,
  output logic [COLOR_W-1:0]        pix_color,
  output logic [ADDR_W-1:0]         pix_addr,
  output logic                      done,
  output logic                      busy
);
  localparam int CW = COORD_W + 2;
  localparam logic signed [CW-1:0] SW = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SH = CW'(SCREEN_H);
  state_t state, state_n;
  logic signed [CW-1:0] cur_x, cur_y, end_x_r, end_y_r, dx, dy, step_x, step_y;
  logic signed [CW-1:0] dif_x, dif_y, abs_x, abs_y, nx, ny;
  logic signed [CW:0] err, nerr;
  logic [COLOR_W-1:0] color;
  logic in_bounds, at_end, adv;
  logic [ADDR_W-1:0] xa, ya;
  bresenham_step #(.CW(CW)) u_step (
    .cur_x(cur_x), .cur_y(cur_y), .end_x(end_x_r), .end_y(end_y_r),
    .dx(dx), .dy(dy), .step_x(step_x), .step_y(step_y), .err(err),
    .next_x(nx), .next_y(ny), .next_err(nerr), .at_end(at_end)
  );
  always_comb begin
    dif_x = end_x_r - cur_x;
    dif_y = end_y_r - cur_y;
    abs_x = dif_x[CW-1] ? -dif_x : dif_x;
    abs_y = dif_y[CW-1] ? -dif_y : dif_y;
    in_bounds = !cur_x[CW-1] && cur_x < SW && !cur_y[CW-1] && cur_y < SH;
    // clipped points advance without waiting for the sink
    adv = state == WALK && (!in_bounds || pix_ready);
    state_n = state;
    case (state)
      IDLE:    state_n = line_valid ? SETUP : IDLE;
      SETUP:   state_n = WALK;
      WALK:    state_n = adv && at_end ? DONE : WALK;
      default: state_n = IDLE;
    endcase
    line_ready = state == IDLE;
    busy = state != IDLE;
    done = state == DONE;
    pix_valid = state == WALK && in_bounds;
    pix_x = cur_x[X_W-1:0];
    pix_y = cur_y[Y_W-1:0];
    pix_color = color;
    xa = ADDR_W'(pix_x);
    ya = ADDR_W'(pix_y);
    // 640 = 512 + 128, so the row offset needs only two shifts and an add
    pix_addr = SCREEN_W == 640 ? (ya << 9) + (ya << 7) + xa : ADDR_W'(ya * SCREEN_W) + xa;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cur_x <= '0;
      cur_y <= '0;
      end_x_r <= '0;
      end_y_r <= '0;
      dx <= '0;
      dy <= '0;
      step_x <= '0;
      step_y <= '0;
      err <= '0;
      color <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && line_valid) begin
        cur_x <= CW'(centre_to_screen(int'(start_x), SCREEN_W/2, 1'b0));
        cur_y <= CW'(centre_to_screen(int'(start_y), SCREEN_H/2, 1'b1));
        end_x_r <= CW'(centre_to_screen(int'(end_x), SCREEN_W/2, 1'b0));
        end_y_r <= CW'(centre_to_screen(int'(end_y), SCREEN_H/2, 1'b1));
        color <= line_color;
      end
      if (state == SETUP) begin
        dx <= abs_x;
        dy <= abs_y;
        step_x <= dif_x[CW-1] ? '1 : CW'(dif_x != 0);
        step_y <= dif_y[CW-1] ? '1 : CW'(dif_y != 0);
        err <= (CW+1)'(abs_x) - (CW+1)'(abs_y);
      end
      if (adv && !at_end) begin
        cur_x <= nx;
        cur_y <= ny;
        err <= nerr;
      end
    end
endmodule

// File: doc/line_raster_stream.md
Name: line_raster_stream

Overview:
- Parametrised successor to the vector-line rasterizer. Takes one line segment in centre-origin, Y-up coordinates and walks it with integer Bresenham (all octants, endpoints inclusive).
- Emits only on-screen pixels as a valid/ready stream. Each pixel carries screen x/y, colour and framebuffer address.
- Sits between the vector display-list engine and the framebuffer write port. Unlike its predecessor, it applies backpressure, clips off-screen pixels, and has parametrised screen size and widths.

Parameters:
- COORD_W, 13, signed input coordinate width.
- SCREEN_W, 640, visible width in pixels (even).
- SCREEN_H, 480, visible height in pixels (even).
- COLOR_W, 4, colour width.
- X_W, $clog2(SCREEN_W), pixel x width.
- Y_W, $clog2(SCREEN_H), pixel y width.
- ADDR_W, $clog2(SCREEN_W*SCREEN_H), framebuffer address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- line_valid  in  1  segment offered
- line_ready  out  1  high in IDLE only
- start_x, start_y, end_x, end_y  in  COORD_W each  signed, centre origin, +y up
- line_color  in  COLOR_W  segment colour
- pix_valid  out  1  pixel offered
- pix_ready  in  1  downstream accepts
- pix_x  out  X_W  screen x, 0 = left
- pix_y  out  Y_W  screen y, 0 = top
- pix_color  out  COLOR_W  latched line_color
- pix_addr  out  ADDR_W  pix_y*SCREEN_W + pix_x
- done  out  1  one-cycle pulse at end of segment
- busy  out  1  not IDLE

Behaviour:
- Reset:
  - state IDLE.
  - pix_valid, done and busy are 0; line_ready is 1.
  - pix_x, pix_y, pix_color and pix_addr are 0.
  - Reset mid-segment aborts immediately. No done pulse. The pending pixel is dropped.
- Accept:
  - Capture occurs on a cycle with line_valid && line_ready.
  - Latched values: sx = start_x + SCREEN_W/2, sy = SCREEN_H/2 - start_y, ex/ey likewise, and colour.
  - Internal arithmetic is signed, COORD_W+2 bits, so no overflow for any input.
- States:
  - IDLE -> SETUP on accept.
  - SETUP, one cycle:
    - dx = |ex-sx|, dy = |ey-sy|.
    - stepx = sign(ex-sx), stepy = sign(ey-sy).
    - err = dx - dy.
    - cur = (sx, sy).
    - SETUP -> WALK.
  - WALK: one point per cycle at most.
    - Point in bounds (0<=cur_x<SCREEN_W and 0<=cur_y<SCREEN_H): pix_valid=1 and outputs are driven from cur. Advance only on pix_ready.
    - Point out of bounds: pix_valid=0; advance unconditionally. Clipped points cost one cycle each.
    - Advance when cur == (ex, ey): go to DONE.
    - Otherwise, with e2 = 2*err:
      - if e2 > -dy: err -= dy, cur_x += stepx.
      - if e2 < dx: err += dx, cur_y += stepy.
      - Both updates may apply in the same cycle.
  - DONE: done=1 for one cycle, then -> IDLE. line_ready returns the following cycle.
- Latency:
  - Accept at cycle N; SETUP at N+1; first point presented at N+2.
  - The segment occupies max(dx,dy)+1 WALK cycles plus stall cycles.
- Output stability:
  - While pix_valid && !pix_ready, all pix_* outputs hold stable.
  - pix_valid never drops without a handshake.
- Zero-length segment: exactly one point is visited, then DONE.
- Fully off-screen segment: zero pixels are emitted; done still pulses.
- Each segment has the same pixel set regardless of pix_ready pattern.
- Inputs are ignored while busy.
- pix_addr is computed combinationally from the registered cur, with a shift-add when SCREEN_W=640. No extra latency.

Decomposition:
- raster_pkg holds:
  - the state enum {IDLE, SETUP, WALK, DONE};
  - helper function for centre-to-screen conversion.
- One sub-module, bresenham_step. It is combinational and computes:
  - next cur_x, cur_y and err from (cur, err, dx, dy, step);
  - the at_end flag.
- The FSM, registers, bounds check and address multiply stay in line_raster_stream.

Test Plan:
- Horizontal line, pix_ready=1: (-320,0)->(-317,0) -> pixels x=0..3, y=240; addr 153600..153603; done pulses on the cycle after the 4th handshake.
- Steep line: (0,0)->(2,-5) -> 6 pixels. y runs 240..245 consecutively; x runs 320..322 monotonically non-decreasing. The first pixel is (320,240); the last is (322,245).
- Backpressure: same as the first scenario with pix_ready low for 3 cycles after the first pixel. Required response:
  - pixel (0,240) is held stable for those 3 cycles;
  - the total pixel set is unchanged;
  - done is delayed by exactly 3 cycles.
- Clipping: (315,0)->(325,0) -> 5 pixels, x=635..639, y=240. done asserts 11 WALK cycles after SETUP.
- Zero-length: (10,10)->(10,10), colour 4'hA -> exactly one pixel (330,230), addr 147530, colour A.
- Reset mid-line: assert rst during WALK of a 100-pixel line. Next cycle: pix_valid=0, busy=0, line_ready=1, no done pulse. A new segment is then accepted normally.
